// File: rtl/fetch_stage_pkg.sv
// Shared constants, opcode values and FSM state encoding for the fetch stage
// and the halt/drain controller.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_halt_drain_ctrl.sv
// Halt/drain FSM: after a halt word is seen, counts non-stalled drain cycles
// and then raises a sticky end_program. A redirect during drain squashes the halt.
import fetch_stage_pkg::*;

module halt_drain_ctrl #(
  parameter int DRAIN_CYCLES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         halt_seen,
  input  logic         stall,
  input  logic         branch_taken,
  output logic         fetch_enable,
  output logic         end_program,
  output fetch_state_t state
);

  localparam int CW = $clog2(DRAIN_CYCLES) + 1;
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

  fetch_state_t  state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          end_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      cnt         <= '0;
      end_program <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      end_program <= end_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    end_nxt   = end_program;
    case (state)
      ST_RUN: begin
        if (halt_seen && !stall && !branch_taken) begin
          state_nxt = ST_DRAIN;
          cnt_nxt   = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        // An older branch resolving here means the halt was on a wrong path.
        if (branch_taken) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else if (!stall) begin
          if (cnt == '0) begin
            state_nxt = ST_DONE;
            end_nxt   = 1'b1;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
      end
      ST_DONE: end_nxt = 1'b1;
      default: state_nxt = ST_RUN;
    endcase
  end

  assign fetch_enable = (state == ST_RUN);

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, addresses imem, and fills the IF/ID latch while
// honouring stalls, branch redirects and the halt/drain sequence.
import fetch_stage_pkg::*;

module fetch_stage #(
  parameter int               XLEN         = 64,
  parameter logic [XLEN-1:0]  RESET_PC     = '0,
  parameter logic [31:0]      NOP_WORD     = NOP_INSTR,
  parameter logic [31:0]      HALT_VALUE   = HALT_WORD,
  parameter int               DRAIN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  input  logic [31:0]      imem_rdata,
  output logic [XLEN-1:0]  imem_addr,
  output logic [XLEN-1:0]  if_id_pc,
  output logic [31:0]      if_id_instr,
  output logic             if_id_valid,
  output logic             end_program,
  output logic [31:0]      fetch_cycles
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] target_aligned;
  logic            fetch_enable;
  logic            halt_seen;
  fetch_state_t    state;

  assign imem_addr      = pc;
  assign target_aligned = branch_target & ~XLEN'(3);
  // Halt decode only counts on an edge that would otherwise advance the PC.
  assign halt_seen      = fetch_enable && !stall && !branch_taken &&
                          (imem_rdata == HALT_VALUE);

  halt_drain_ctrl #(
    .DRAIN_CYCLES (DRAIN_CYCLES)
  ) u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .halt_seen    (halt_seen),
    .stall        (stall),
    .branch_taken (branch_taken),
    .fetch_enable (fetch_enable),
    .end_program  (end_program),
    .state        (state)
  );

  // if_id_valid qualifies the latch contents; stall holds both the PC and the
  // latch, and a redirect overrides stall by loading a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      if_id_pc    <= '0;
      if_id_instr <= NOP_WORD;
      if_id_valid <= 1'b0;
    end else if (fetch_enable) begin
      if (branch_taken) begin
        pc          <= target_aligned;
        if_id_instr <= NOP_WORD;
        if_id_valid <= 1'b0;
      end else if (stall) begin
        pc <= pc;
      end else if (imem_rdata == HALT_VALUE) begin
        if_id_instr <= NOP_WORD;
        if_id_valid <= 1'b0;
      end else begin
        if_id_pc    <= pc;
        if_id_instr <= imem_rdata;
        if_id_valid <= 1'b1;
        pc          <= pc + XLEN'(4);
      end
    end else if (state == ST_DRAIN) begin
      if (branch_taken) pc <= target_aligned;
      if_id_instr <= NOP_WORD;
      if_id_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cycles <= '0;
    end else if (state != ST_DONE) begin
      fetch_cycles <= fetch_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small combinational imem model.
module tb_fetch_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] I0   = 32'h0010_0093;
  localparam logic [31:0] I1   = 32'h0020_0113;
  localparam logic [31:0] I2   = 32'h0030_0193;
  localparam logic [31:0] I3   = 32'h0040_0213;
  localparam logic [31:0] I7   = 32'h0070_0393;
  localparam logic [31:0] I8   = 32'h0080_0413;
  localparam logic [31:0] I63  = 32'h03F0_0F93;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [31:0] imem_rdata;
  logic [63:0] imem_addr;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        end_program;
  logic [31:0] fetch_cycles;

  logic [31:0] imem [0:63];
  int          tests_run    = 0;
  int          tests_failed = 0;

  assign imem_rdata = imem[imem_addr[7:2]];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_rdata    (imem_rdata),
    .imem_addr     (imem_addr),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid),
    .end_program   (end_program),
    .fetch_cycles  (fetch_cycles)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic load_prog(input int halt_idx);
    for (int i = 0; i < 64; i++) imem[i] = NOP;
    imem[0]  = I0;
    imem[1]  = I1;
    imem[2]  = I2;
    imem[3]  = I3;
    imem[7]  = I7;
    imem[8]  = I8;
    imem[63] = I63;
    imem[halt_idx] = HALT;
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    load_prog(3);
    tick(2);
    reset = 1'b0;

    // Reset state
    check("rst_addr", imem_addr, 64'h0);
    check("rst_valid", {63'b0, if_id_valid}, 64'h0);
    check("rst_instr", {32'b0, if_id_instr}, {32'b0, NOP});
    check("rst_pc", if_id_pc, 64'h0);
    check("rst_end", {63'b0, end_program}, 64'h0);
    check("rst_cycles", {32'b0, fetch_cycles}, 64'h0);

    // Straight line to halt at 12
    tick(1);
    check("sl_pc0", if_id_pc, 64'h0);
    check("sl_instr0", {32'b0, if_id_instr}, {32'b0, I0});
    check("sl_valid0", {63'b0, if_id_valid}, 64'h1);
    tick(1);
    check("sl_pc4", if_id_pc, 64'h4);
    tick(1);
    check("sl_pc8", if_id_pc, 64'h8);
    check("sl_addr12", imem_addr, 64'hC);
    tick(1);
    check("sl_halt_valid", {63'b0, if_id_valid}, 64'h0);
    check("sl_halt_instr", {32'b0, if_id_instr}, {32'b0, NOP});
    check("sl_halt_addr", imem_addr, 64'hC);
    tick(3);
    check("sl_end_early", {63'b0, end_program}, 64'h0);
    tick(1);
    check("sl_end", {63'b0, end_program}, 64'h1);
    check("sl_cycles", {32'b0, fetch_cycles}, 64'd8);
    stall = 1'b1;
    branch_taken = 1'b1;
    branch_target = 64'h40;
    tick(3);
    stall = 1'b0;
    branch_taken = 1'b0;
    check("done_cycles", {32'b0, fetch_cycles}, 64'd8);
    check("done_addr", imem_addr, 64'hC);
    check("done_end", {63'b0, end_program}, 64'h1);

    // Reset in DONE
    do_reset();
    check("rd_end", {63'b0, end_program}, 64'h0);
    check("rd_addr", imem_addr, 64'h0);
    check("rd_valid", {63'b0, if_id_valid}, 64'h0);
    check("rd_cycles", {32'b0, fetch_cycles}, 64'h0);
    tick(1);
    check("rd_restart_instr", {32'b0, if_id_instr}, {32'b0, I0});
    check("rd_restart_pc", if_id_pc, 64'h0);

    // Stall at PC=8
    tick(1);
    check("st_addr8", imem_addr, 64'h8);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      check("st_hold_addr", imem_addr, 64'h8);
      check("st_hold_pc", if_id_pc, 64'h4);
      check("st_hold_instr", {32'b0, if_id_instr}, {32'b0, I1});
    end
    check("st_cycles", {32'b0, fetch_cycles}, 64'd4);
    stall = 1'b0;
    tick(1);
    check("st_resume_addr", imem_addr, 64'hC);
    check("st_resume_pc", if_id_pc, 64'h8);

    // Halt word under stall must not be decoded
    stall = 1'b1;
    tick(1);
    check("gate_valid", {63'b0, if_id_valid}, 64'h1);
    check("gate_pc", if_id_pc, 64'h8);
    stall = 1'b0;

    // Stall mid-drain delays end_program by the stall length
    tick(1);
    check("sd_detect_valid", {63'b0, if_id_valid}, 64'h0);
    tick(1);
    stall = 1'b1;
    tick(3);
    check("sd_stalled_end", {63'b0, end_program}, 64'h0);
    stall = 1'b0;
    tick(2);
    check("sd_end_early", {63'b0, end_program}, 64'h0);
    tick(1);
    check("sd_end", {63'b0, end_program}, 64'h1);

    // Redirect during stall, then PC wrap
    do_reset();
    tick(1);
    check("rs_addr4", imem_addr, 64'h4);
    stall = 1'b1;
    branch_taken = 1'b1;
    branch_target = 64'h1E;
    tick(1);
    stall = 1'b0;
    branch_taken = 1'b0;
    check("rs_addr", imem_addr, 64'h1C);
    check("rs_valid", {63'b0, if_id_valid}, 64'h0);
    check("rs_instr", {32'b0, if_id_instr}, {32'b0, NOP});
    tick(1);
    check("rs_fetch_pc", if_id_pc, 64'h1C);
    check("rs_fetch_instr", {32'b0, if_id_instr}, {32'b0, I7});
    branch_taken = 1'b1;
    branch_target = 64'hFFFF_FFFF_FFFF_FFFF;
    tick(1);
    branch_taken = 1'b0;
    check("wrap_target", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick(1);
    check("wrap_addr", imem_addr, 64'h0);
    check("wrap_pc", if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_instr", {32'b0, if_id_instr}, {32'b0, I63});

    // Speculative halt at imem[4] squashed, later halt at imem[9] completes
    load_prog(4);
    imem[9] = HALT;
    do_reset();
    tick(4);
    check("sq_addr16", imem_addr, 64'h10);
    tick(2);
    branch_taken = 1'b1;
    branch_target = 64'h20;
    tick(1);
    branch_taken = 1'b0;
    check("sq_addr", imem_addr, 64'h20);
    check("sq_valid", {63'b0, if_id_valid}, 64'h0);
    tick(1);
    check("sq_run_pc", if_id_pc, 64'h20);
    check("sq_run_instr", {32'b0, if_id_instr}, {32'b0, I8});
    check("sq_run_end", {63'b0, end_program}, 64'h0);
    tick(4);
    check("sq_late_end_early", {63'b0, end_program}, 64'h0);
    tick(1);
    check("sq_late_end", {63'b0, end_program}, 64'h1);
    check("sq_late_addr", imem_addr, 64'h24);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of cpu_pipelined, directly upstream of ID.
- Owns the PC register and drives the instruction-memory address; imem returns the instruction combinationally.
- Registers the fetched instruction and PC into the IF/ID latch, honouring hazard stalls and branch redirects.
- Detects the all-ones halt word, drains the pipeline, then raises end_program.

Parameters:
- XLEN, 64, PC/address width.
- RESET_PC, 0, PC value after reset.
- NOP_INSTR, 32'h00000013, bubble inserted into IF/ID (addi x0,x0,0).
- HALT_WORD, 32'hFFFFFFFF, end-of-program sentinel.
- DRAIN_CYCLES, 4, non-stalled cycles from halt detection to end_program.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hazard unit: hold PC and IF/ID.
- branch_taken  in  1  redirect request from the resolving stage.
- branch_target  in  XLEN  redirect PC.
- imem_rdata  in  32  instruction at imem_addr (combinational).
- imem_addr  out  XLEN  current PC, driven from the PC register.
- if_id_pc  out  XLEN  PC of the latched instruction.
- if_id_instr  out  32  latched instruction.
- if_id_valid  out  1  latched instruction is real, not a bubble.
- end_program  out  1  sticky halt-complete flag.
- fetch_cycles  out  32  cycles spent in RUN plus DRAIN.

Behaviour:
- Reset, synchronous and dominant over everything:
  - PC=RESET_PC, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0.
  - end_program=0, fetch_cycles=0, drain counter=0, state=RUN.
  - Reset asserted mid-drain or in DONE returns to RUN the next edge.
- States: RUN, DRAIN, DONE.
- RUN, per edge, in priority order:
  1. branch_taken: PC={branch_target[XLEN-1:2],2'b00}; IF/ID=NOP, valid=0. Redirect wins over stall.
  2. stall: PC and IF/ID hold.
  3. imem_rdata==HALT_WORD: PC holds; IF/ID=NOP, valid=0; counter=DRAIN_CYCLES-1; go to DRAIN.
  4. Otherwise: IF/ID={PC, imem_rdata, valid=1}; PC=PC+4, modulo 2^XLEN (all-ones-minus-3 wraps to 0).
- DRAIN:
  - branch_taken: an older branch has squashed the speculative halt. PC=aligned target, IF/ID=NOP, counter=0, back to RUN.
  - stall: counter holds.
  - Otherwise, counter==0: go to DONE and set end_program. Else decrement the counter.
  - IF/ID stays NOP, valid=0, throughout.
- Latency: with no stalls, end_program rises exactly DRAIN_CYCLES edges after the detection edge.
- DONE:
  - end_program=1, sticky.
  - PC, IF/ID and fetch_cycles frozen.
  - stall and branch_taken ignored. Only reset leaves DONE.
- fetch_cycles: +1 on every non-reset edge while state is RUN or DRAIN, including stalled cycles. Wraps at 2^32.
- imem_addr equals the PC register at all times. imem word index is imem_addr[XLEN-1:2].
- Halt decode is gated: no halt detection on a stalled or redirected edge.

Decomposition:
- Shared header cpu_defs.vh holds NOP_INSTR, HALT_WORD, the opcode localparams (R, LOAD, STORE, BRANCH, OP_IMM) and the state encodings RUN=2'd0, DRAIN=2'd1, DONE=2'd2.
- One sub-module, halt_drain_ctrl, owns the FSM, drain counter and end_program.
  - Inputs: halt_seen, stall, branch_taken.
  - Outputs: fetch_enable, end_program.
- PC and IF/ID registers stay in fetch_stage.

Test Plan:
- Straight line: imem[0..2]=addi words, imem[3]=HALT_WORD, no stall or branch.
  - if_id_pc steps 0,4,8 with valid=1.
  - PC holds at 12.
  - end_program rises 4 edges after PC reaches 12 and the halt is seen.
  - fetch_cycles then freezes.
- Stall: assert stall for 2 cycles while PC=8.
  - PC stays 8; if_id_instr/if_id_pc unchanged both cycles.
  - Resumes at 8→12 after deassertion.
- Redirect during stall: stall=1, branch_taken=1, branch_target=0x1E at PC=4.
  - Next PC=0x1C, if_id_valid=0, if_id_instr=0x00000013.
- Speculative halt squashed: HALT_WORD at imem[4]; branch_taken with target 0x20 on the 2nd DRAIN cycle.
  - State returns to RUN, PC=0x20, end_program stays 0.
  - A later halt completes normally.
- Stall during drain: stall for 3 cycles mid-drain.
  - end_program is delayed by exactly 3 cycles (DRAIN_CYCLES+3 edges after detection).
- Reset in DONE: assert reset one cycle.
  - end_program=0, PC=RESET_PC, if_id_valid=0, fetch_cycles=0.
  - Fetch restarts from imem[0].
